// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM state encoding and the default
// run-length counter width.
package pulse_meter_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [1:0] ST_WAIT     = 2'b00;
  localparam logic [1:0] ST_RUN_HIGH = 2'b01;
  localparam logic [1:0] ST_RUN_LOW  = 2'b10;

endpackage

// File: rtl/pulse_meter_edge_detect.sv
// Edge detector for the debounced input: keeps the previous sample and flags
// rising and falling transitions combinationally against the current level.
module edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sigD;

  // Previous level clears to 0, so a high input right after reset reads as a rise.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sigD <= 1'b0;
    end else begin
      r_sigD <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sigD;
  assign o_fall = ~i_sig & r_sigD;

endmodule

// File: rtl/pulse_meter.sv
// Measures the length of each completed high pulse or low gap on sig_in and
// presents it through a valid/ready output register with a sticky overrun flag.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_len,
  output logic             meas_level,
  output logic             meas_sat,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_rise;
  logic             w_fall;
  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_satFlag;
  logic             w_nextSat;
  logic             w_emit;
  logic             w_emitLevel;
  logic             w_canLoad;
  logic             w_accept;
  logic             w_drop;
  logic [CNT_W-1:0] r_measLen;
  logic             r_measLevel;
  logic             r_measSat;
  logic             r_measValid;
  logic             r_overrun;

  edge_detect u_edge (
    .i_clock (clock),
    .i_reset (reset),
    .i_sig   (sig_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The run in progress at reset has an unknown start, so WAIT only arms on an edge.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextSat   = r_satFlag;
    w_emit      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_rise) begin
          w_nextState = ST_RUN_HIGH;
          w_nextCnt   = CNT_ONE;
          w_nextSat   = 1'b0;
        end else if (w_fall) begin
          w_nextState = ST_RUN_LOW;
          w_nextCnt   = CNT_ONE;
          w_nextSat   = 1'b0;
        end
      end
      ST_RUN_HIGH: begin
        if (w_fall) begin
          w_emit      = 1'b1;
          w_nextState = ST_RUN_LOW;
          w_nextCnt   = CNT_ONE;
          w_nextSat   = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          w_nextSat = 1'b1;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      ST_RUN_LOW: begin
        if (w_rise) begin
          w_emit      = 1'b1;
          w_nextState = ST_RUN_HIGH;
          w_nextCnt   = CNT_ONE;
          w_nextSat   = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          w_nextSat = 1'b1;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = ST_WAIT;
        w_nextCnt   = '0;
        w_nextSat   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_WAIT;
      r_cnt     <= '0;
      r_satFlag <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_satFlag <= w_nextSat;
    end
  end

  assign w_emitLevel = (r_state == ST_RUN_HIGH);
  assign w_canLoad   = ~r_measValid | meas_ready;
  assign w_accept    = r_measValid & meas_ready;
  assign w_drop      = w_emit & ~w_canLoad;

  // A result arriving on the same edge the old one is taken replaces it with no bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_measLen   <= '0;
      r_measLevel <= 1'b0;
      r_measSat   <= 1'b0;
      r_measValid <= 1'b0;
    end else if (w_emit && w_canLoad) begin
      r_measLen   <= r_cnt;
      r_measLevel <= w_emitLevel;
      r_measSat   <= r_satFlag;
      r_measValid <= 1'b1;
    end else if (w_accept) begin
      r_measValid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign meas_len   = r_measLen;
  assign meas_level = r_measLevel;
  assign meas_sat   = r_measSat;
  assign meas_valid = r_measValid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed scenarios plus randomized runs,
// two widths (8 and 4) checked every cycle against a run-length reference model.
module tb_pulse_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sigIn = 1'b0;
  logic       measReady = 1'b0;
  logic       ovrClr = 1'b0;

  logic [7:0] len8;
  logic       lvl8, sat8, valid8, ovr8;
  logic [3:0] len4;
  logic       lvl4, sat4, valid4, ovr4;

  int assertCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  pulse_meter #(.CNT_W(8)) dut8 (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sigIn),
    .meas_len   (len8),
    .meas_level (lvl8),
    .meas_sat   (sat8),
    .meas_valid (valid8),
    .meas_ready (measReady),
    .overrun    (ovr8),
    .ovr_clr    (ovrClr)
  );

  pulse_meter #(.CNT_W(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sigIn),
    .meas_len   (len4),
    .meas_level (lvl4),
    .meas_sat   (sat4),
    .meas_valid (valid4),
    .meas_ready (measReady),
    .overrun    (ovr4),
    .ovr_clr    (ovrClr)
  );

  typedef struct packed {
    logic       lvl;
    logic [7:0] len;
    logic       sat;
  } meas_t;

  meas_t seen8[$];
  meas_t seen4[$];

  // Reference: track true (unbounded) run length from level changes; index 0 is the
  // 8-bit instance, index 1 the 4-bit one, which differ only in the clamp value.
  typedef struct packed {
    logic            prev;
    logic            known;
    logic            runLvl;
    logic [15:0]     runLen;
    logic [1:0]      valid;
    logic [1:0]      lvl;
    logic [1:0]      sat;
    logic [1:0]      ovr;
    logic [1:0][7:0] len;
  } model_t;

  model_t mdl;

  function automatic model_t stepModel(model_t m, logic s, logic rdy, logic clr);
    model_t n = m;
    logic emit = 1'b0;
    logic eLvl = 1'b0;
    int eLen = 0;
    int maxV;
    if (s != m.prev) begin
      if (m.known) begin
        emit = 1'b1;
        eLvl = m.runLvl;
        eLen = int'(m.runLen);
      end
      n.known  = 1'b1;
      n.runLvl = s;
      n.runLen = 16'd1;
    end else if (m.known) begin
      n.runLen = m.runLen + 16'd1;
    end
    n.prev = s;
    for (int i = 0; i < 2; i++) begin
      maxV = (i == 0) ? 255 : 15;
      if (emit && (!m.valid[i] || rdy)) begin
        n.valid[i] = 1'b1;
        n.lvl[i]   = eLvl;
        n.len[i]   = 8'((eLen > maxV) ? maxV : eLen);
        n.sat[i]   = (eLen > maxV);
      end else if (m.valid[i] && rdy) begin
        n.valid[i] = 1'b0;
      end
      if (emit && m.valid[i] && !rdy) n.ovr[i] = 1'b1;
      else if (clr) n.ovr[i] = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) mdl <= '0;
    else mdl <= stepModel(mdl, sigIn, measReady, ovrClr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic compareModel();
    checkOutput("valid8", 32'(valid8), 32'(mdl.valid[0]));
    checkOutput("len8", 32'(len8), 32'(mdl.len[0]));
    checkOutput("level8", 32'(lvl8), 32'(mdl.lvl[0]));
    checkOutput("sat8", 32'(sat8), 32'(mdl.sat[0]));
    checkOutput("overrun8", 32'(ovr8), 32'(mdl.ovr[0]));
    checkOutput("valid4", 32'(valid4), 32'(mdl.valid[1]));
    checkOutput("len4", 32'(len4), 32'(mdl.len[1][3:0]));
    checkOutput("level4", 32'(lvl4), 32'(mdl.lvl[1]));
    checkOutput("sat4", 32'(sat4), 32'(mdl.sat[1]));
    checkOutput("overrun4", 32'(ovr4), 32'(mdl.ovr[1]));
    if (valid8) checkOutput("len8_nonzero", 32'(len8 != 8'd0), 32'd1);
    if (valid4) checkOutput("len4_nonzero", 32'(len4 != 4'd0), 32'd1);
  endtask

  // One cycle: check outputs, drive next inputs, and log results the coming edge accepts.
  task automatic tick(input logic s, input logic rdy, input logic clr);
    @(negedge clock);
    compareModel();
    sigIn = s;
    measReady = rdy;
    ovrClr = clr;
    if (valid8 && rdy) seen8.push_back(meas_t'({lvl8, len8, sat8}));
    if (valid4 && rdy) seen4.push_back(meas_t'({lvl4, {4'b0000, len4}, sat4}));
  endtask

  task automatic applyStimulus(input logic s, input logic rdy, input logic clr, input int n);
    repeat (n) tick(s, rdy, clr);
  endtask

  task automatic doReset();
    @(negedge clock);
    sigIn = 1'b0;
    measReady = 1'b0;
    ovrClr = 1'b0;
    reset = 1'b0;
    seen8.delete();
    seen4.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic meas_t getSeen8(int i);
    if (i < seen8.size()) return seen8[i];
    return '1;
  endfunction

  function automatic meas_t getSeen4(int i);
    if (i < seen4.size()) return seen4[i];
    return '1;
  endfunction

  task automatic checkEntry(input string name, input meas_t m, input logic l, input int n, input logic s);
    checkOutput({name, "_level"}, 32'(m.lvl), 32'(l));
    checkOutput({name, "_len"}, 32'(m.len), 32'(n));
    checkOutput({name, "_sat"}, 32'(m.sat), 32'(s));
  endtask

  initial begin
    logic lvl;
    int runLen;

    #1 reset = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(valid8), 32'd0);
    checkOutput("rst_len", 32'(len8), 32'd0);
    checkOutput("rst_level", 32'(lvl8), 32'd0);
    checkOutput("rst_sat", 32'(sat8), 32'd0);
    checkOutput("rst_overrun", 32'(ovr8), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // First edge after reset only arms the meter; the high run is reported at the fall.
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("first_noemit_count", 32'(seen8.size()), 32'd0);
    checkOutput("first_noemit_valid", 32'(valid8), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("first_valid", 32'(valid8), 32'd1);
    checkOutput("first_count", 32'(seen8.size()), 32'd1);
    checkEntry("first", getSeen8(0), 1'b1, 5, 1'b0);

    // High 3, low 4, high 2.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    checkOutput("seq_count2", 32'(seen8.size()), 32'd2);
    checkEntry("seq0", getSeen8(0), 1'b1, 3, 1'b0);
    checkEntry("seq1", getSeen8(1), 1'b0, 4, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("seq_third_pending", 32'(seen8.size()), 32'd2);
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("seq_count3", 32'(seen8.size()), 32'd3);
    checkEntry("seq2", getSeen8(2), 1'b1, 2, 1'b0);

    // Saturation on the 4-bit instance.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    tick(1'b0, 1'b1, 1'b0);
    checkEntry("sat4", getSeen4(0), 1'b1, 15, 1'b1);
    checkEntry("nosat8", getSeen8(0), 1'b1, 20, 1'b0);

    // Stalled consumer: held result, dropped second result, overrun set then cleared.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    tick(1'b0, 1'b0, 1'b0);
    checkOutput("stall_valid", 32'(valid8), 32'd1);
    checkOutput("stall_len", 32'(len8), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checkOutput("stall_hold_len", 32'(len8), 32'd3);
    checkOutput("stall_hold_level", 32'(lvl8), 32'd1);
    checkOutput("stall_overrun8", 32'(ovr8), 32'd1);
    checkOutput("stall_overrun4", 32'(ovr4), 32'd1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    checkOutput("ovr_cleared", 32'(ovr8), 32'd0);
    checkOutput("ovr_clr_keeps_valid", 32'(valid8), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    checkOutput("stall_drain_count", 32'(seen8.size()), 32'd1);
    checkEntry("stall_drain", getSeen8(0), 1'b1, 3, 1'b0);

    // Acceptance on the same edge as a new emit.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checkOutput("b2b_valid", 32'(valid8), 32'd1);
    checkOutput("b2b_len", 32'(len8), 32'd4);
    checkOutput("b2b_level", 32'(lvl8), 32'd0);
    checkOutput("b2b_overrun", 32'(ovr8), 32'd0);
    checkOutput("b2b_count", 32'(seen8.size()), 32'd1);
    checkEntry("b2b_first", getSeen8(0), 1'b1, 3, 1'b0);

    // Asynchronous reset mid-run with a result pending and overrun set.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("pre_rst_valid", 32'(valid8), 32'd1);
    checkOutput("pre_rst_overrun", 32'(ovr8), 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_valid", 32'(valid8), 32'd0);
    checkOutput("async_len", 32'(len8), 32'd0);
    checkOutput("async_level", 32'(lvl8), 32'd0);
    checkOutput("async_overrun", 32'(ovr8), 32'd0);
    checkOutput("async_valid4", 32'(valid4), 32'd0);
    sigIn = 1'b0;
    seen8.delete();
    seen4.delete();
    @(negedge clock);
    #2 reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("post_rst_noemit", 32'(seen8.size()), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_count", 32'(seen8.size()), 32'd1);
    checkEntry("post_rst", getSeen8(0), 1'b1, 4, 1'b0);

    // Randomized runs with random back-pressure and overrun clears.
    doReset();
    lvl = 1'($urandom_range(0, 1));
    for (int r = 0; r < 80; r++) begin
      runLen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300))
                                           : int'($urandom_range(1, 24));
      for (int c = 0; c < runLen; c++) begin
        tick(lvl, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
      end
      lvl = ~lvl;
    end
    applyStimulus(lvl, 1'b1, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
